// File: rtl/wdat_frame_tx.sv
// ============================================================================
// wdat_frame_tx : 3WI write-frame serialiser (START, DATA MSB-first, PARITY, GAP)
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wdat_frame_tx #(
  parameter int FRAME_W    = 52,
  parameter int GAP_CYCLES = 2,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk_3wi,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] wdat_data,
  input  logic               wdat_valid,
  output logic               wdat_ready,
  output logic               wdat_sd,
  output logic               wdat_fs,
  output logic               tx_busy,
  output logic               tx_done,
  output logic [15:0]        frame_cnt
);

  localparam int CNT_W = $clog2(((FRAME_W > GAP_CYCLES) ? FRAME_W : GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [FRAME_W-1:0]   buf_q, buf_d;
  logic                 buf_full_q, buf_full_d;
  logic                 parity_q, parity_d;
  logic                 ready_q, ready_d;
  logic                 sd_q, sd_d;
  logic                 fs_q, fs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic                 load;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    parity_d    = parity_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (buf_full_q) load = 1'b1;
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == LAST_DATA) begin
          state_d = S_PARITY;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          shift_d = shift_q << 1;
        end
      end
      S_PARITY: begin
        state_d     = S_GAP;
        cnt_d       = '0;
        done_d      = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end
      S_GAP: begin
        if (cnt_q == LAST_GAP) begin
          if (buf_full_q) load = 1'b1;
          else            state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Parity is frozen at load time so the buffer can refill during the frame.
    if (load) begin
      state_d    = S_START;
      shift_d    = buf_q;
      parity_d   = (^buf_q) ^ PARITY_ODD;
      buf_full_d = 1'b0;
    end

    if (wdat_valid && ready_q) begin
      buf_d      = wdat_data;
      buf_full_d = 1'b1;
    end

    // Outputs are registered copies of what the next state will drive.
    ready_d = !buf_full_d;
    busy_d  = (state_d != S_IDLE) || buf_full_d;
    sd_d    = 1'b1;
    fs_d    = 1'b0;
    case (state_d)
      S_START:  begin sd_d = 1'b0;               fs_d = 1'b1; end
      S_DATA:   begin sd_d = shift_d[FRAME_W-1]; fs_d = 1'b1; end
      S_PARITY: begin sd_d = parity_d;           fs_d = 1'b1; end
      default:  begin sd_d = 1'b1;               fs_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk_3wi or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      parity_q    <= 1'b0;
      ready_q     <= 1'b0;
      sd_q        <= 1'b1;
      fs_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      parity_q    <= parity_d;
      ready_q     <= ready_d;
      sd_q        <= sd_d;
      fs_q        <= fs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign wdat_ready = ready_q;
  assign wdat_sd    = sd_q;
  assign wdat_fs    = fs_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wdat_frame_tx.sv
// ============================================================================
// tb_wdat_frame_tx : scoreboard bench for wdat_frame_tx
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wdat_frame_tx;

  localparam int FW  = 52;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] wdat_data = '0;
  logic          wdat_valid = 1'b0;
  logic          wdat_ready, wdat_sd, wdat_fs, tx_busy, tx_done;
  logic [15:0]   frame_cnt;

  logic [FW-1:0] o_data = '0;
  logic          o_valid = 1'b0;
  logic          o_ready, o_sd, o_fs, o_busy, o_done;
  logic [15:0]   o_cnt;

  always #5 clk = ~clk;

  wdat_frame_tx #(.FRAME_W(FW), .GAP_CYCLES(GAP), .PARITY_ODD(1'b0)) dut (
    .clk_3wi(clk), .rst_n(rst_n), .wdat_data(wdat_data), .wdat_valid(wdat_valid),
    .wdat_ready(wdat_ready), .wdat_sd(wdat_sd), .wdat_fs(wdat_fs),
    .tx_busy(tx_busy), .tx_done(tx_done), .frame_cnt(frame_cnt)
  );

  wdat_frame_tx #(.FRAME_W(FW), .GAP_CYCLES(GAP), .PARITY_ODD(1'b1)) dut_odd (
    .clk_3wi(clk), .rst_n(rst_n), .wdat_data(o_data), .wdat_valid(o_valid),
    .wdat_ready(o_ready), .wdat_sd(o_sd), .wdat_fs(o_fs),
    .tx_busy(o_busy), .tx_done(o_done), .frame_cnt(o_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    logic [FW-1:0] data;
    int            acc_cyc;
  } entry_t;

  entry_t      sb_q[$];
  int          cyc = 0;
  int          last_acc = 0;
  int          last_par = -1000;
  logic [15:0] exp_cnt = 16'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: reassembles each serial frame and checks it against the scoreboard.
  initial begin : mon
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        exp_cnt  = 16'd0;
        last_par = -1000;
        continue;
      end
      if (!wdat_fs) continue;
      begin : frame
        logic [FW-1:0] got;
        logic          fs_ok, aborted, par;
        int            st, exp_st, par_cyc;
        entry_t        e;
        st = cyc; fs_ok = 1'b1; aborted = 1'b0; got = '0; par = 1'b0; par_cyc = 0;
        check_val("start_sd", wdat_sd, 0);
        for (int i = FW - 1; i >= 0; i--) begin
          @(negedge clk);
          if (!rst_n) begin aborted = 1'b1; break; end
          got[i] = wdat_sd;
          fs_ok &= wdat_fs;
        end
        if (!aborted) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          else begin par = wdat_sd; fs_ok &= wdat_fs; par_cyc = cyc; end
        end
        if (aborted) begin
          sb_q.delete();
          exp_cnt  = 16'd0;
          last_par = -1000;
        end else begin
          check_val("sb_nonempty", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            exp_st = (e.acc_cyc + 1 > last_par + GAP + 1) ? e.acc_cyc + 1 : last_par + GAP + 1;
            check_val("start_time", st, exp_st);
            check_val("data", got, e.data);
            check_val("parity", par, ^e.data);
          end
          check_val("fs_window", fs_ok, 1);
          last_par = par_cyc;
          @(negedge clk);
          exp_cnt = exp_cnt + 16'd1;
          check_val("done_pulse", tx_done, 1);
          check_val("gap_sd", wdat_sd, 1);
          check_val("gap_fs", wdat_fs, 0);
          check_val("frame_cnt", frame_cnt, exp_cnt);
          @(negedge clk);
          check_val("done_single", tx_done, 0);
        end
      end
    end
  end

  task automatic send_word(input logic [FW-1:0] d);
    int t;
    @(negedge clk);
    wdat_data  = d;
    wdat_valid = 1'b1;
    t = 0;
    while (!wdat_ready && t < 500) begin @(negedge clk); t++; end
    check_val("accept_wait", (t < 500), 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    sb_q.push_back('{d, cyc});
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || tx_busy) && t < 2000) begin @(negedge clk); t++; end
    check_val("drain", (t < 2000), 1);
  endtask

  task automatic odd_frame(input string tag, input logic [FW-1:0] d, input logic exp_par);
    int t;
    @(negedge clk);
    o_data  = d;
    o_valid = 1'b1;
    t = 0;
    while (!o_ready && t < 500) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk);
    o_valid = 1'b0;
    t = 0;
    while (!o_fs && t < 50) begin @(negedge clk); t++; end
    check_val("odd_start", (o_fs && !o_sd), 1);
    repeat (FW + 1) @(negedge clk);
    check_val(tag, o_sd, exp_par);
    check_val("odd_par_fs", o_fs, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [FW-1:0] w;
    logic          done_seen;

    wdat_valid = 1'b1;
    wdat_data  = 52'h123;
    repeat (3) @(negedge clk);
    check_val("rst_sd", wdat_sd, 1);
    check_val("rst_fs", wdat_fs, 0);
    check_val("rst_ready", wdat_ready, 0);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_done", tx_done, 0);
    check_val("rst_cnt", frame_cnt, 0);
    wdat_valid = 1'b0;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
    check_val("ready_after_rst", wdat_ready, 1);
    repeat (5) @(negedge clk);
    check_val("idle_fs", wdat_fs, 0);
    check_val("idle_sd", wdat_sd, 1);
    check_val("idle_busy", tx_busy, 0);

    send_word(52'h8_0000_0000_0001);
    @(negedge clk) wdat_valid = 1'b0;
    wait_drain();
    check_val("cnt_single", frame_cnt, 1);

    send_word(52'h0);
    @(negedge clk) wdat_valid = 1'b0;
    wait_drain();
    send_word(52'hF_FFFF_FFFF_FFFF);
    @(negedge clk) wdat_valid = 1'b0;
    wait_drain();
    check_val("cnt_parity", frame_cnt, 3);

    for (int k = 0; k < 3; k++) begin
      w = {$urandom, $urandom};
      send_word(w);
      if (k == 1) begin
        @(negedge clk);
        check_val("ready_full", wdat_ready, 0);
        check_val("busy_full", tx_busy, 1);
      end
    end
    @(negedge clk) wdat_valid = 1'b0;
    wait_drain();
    check_val("cnt_b2b", frame_cnt, 6);

    send_word(52'hA_5A5A_5A5A_5A5A);
    @(negedge clk) wdat_valid = 1'b0;
    while (cyc < last_acc + 22) @(negedge clk);
    check_val("mid_frame_fs", wdat_fs, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_sd", wdat_sd, 1);
    check_val("abort_fs", wdat_fs, 0);
    check_val("abort_cnt", frame_cnt, 0);
    check_val("abort_ready", wdat_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (70) begin @(negedge clk); done_seen |= tx_done; end
    check_val("abort_no_done", done_seen, 0);
    check_val("abort_no_fs", wdat_fs, 0);
    send_word(52'h1_2345_6789_ABCD);
    @(negedge clk) wdat_valid = 1'b0;
    wait_drain();
    check_val("cnt_after_abort", frame_cnt, 1);

    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check_val("cnt_preload", frame_cnt, 16'hFFFF);
    send_word(52'h3_C3C3_C3C3_C3C3);
    @(negedge clk) wdat_valid = 1'b0;
    wait_drain();
    check_val("cnt_wrap", frame_cnt, 0);

    odd_frame("odd_parity_zero", 52'h0, 1'b1);
    odd_frame("odd_parity_ones", 52'hF_FFFF_FFFF_FFFF, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
